// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running up-counter bus: locks after a run of
// correct increments, then flags/counts mismatches and counts wrap-arounds.
module counter_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_LEN = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] q_in,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] wrap_cnt
);

   localparam int RUN_W = $clog2(LOCK_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_TRACK,
      S_LOCKED
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] prev, prev_nxt, prev_inc;
   logic [RUN_W-1:0] run, run_nxt, run_inc;
   logic             err_nxt;
   logic [CNT_W-1:0] err_cnt_nxt, wrap_cnt_nxt;
   logic             match;

   assign prev_inc = prev + WIDTH'(1);
   assign run_inc  = run + RUN_W'(1);
   assign match    = (q_in == prev_inc);

   // Next-state and next-output logic; en low overrides everything, so a
   // mismatch on the same edge produces no error pulse.
   always_comb begin
      state_nxt    = state;
      prev_nxt     = prev;
      run_nxt      = run;
      err_nxt      = 1'b0;
      err_cnt_nxt  = err_cnt;
      wrap_cnt_nxt = wrap_cnt;
      if (!en) begin
         state_nxt = S_IDLE;
         run_nxt   = '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               prev_nxt  = q_in;
               run_nxt   = '0;
               state_nxt = S_SYNC;
            end
            S_SYNC, S_TRACK: begin
               prev_nxt = q_in;
               if (match) begin
                  run_nxt   = run_inc;
                  state_nxt = (run_inc >= RUN_W'(LOCK_LEN)) ? S_LOCKED : S_TRACK;
               end else begin
                  run_nxt   = '0;
                  state_nxt = S_SYNC;
               end
            end
            S_LOCKED: begin
               prev_nxt = q_in;
               if (match) begin
                  // Only wraps taken while already locked are counted
                  if ((&prev) && !(&wrap_cnt))
                     wrap_cnt_nxt = wrap_cnt + CNT_W'(1);
               end else begin
                  err_nxt   = 1'b1;
                  run_nxt   = '0;
                  state_nxt = S_SYNC;
                  if (!(&err_cnt))
                     err_cnt_nxt = err_cnt + CNT_W'(1);
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // All state and outputs registered; locked mirrors the registered state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         prev     <= '0;
         run      <= '0;
         locked   <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
         wrap_cnt <= '0;
      end else begin
         state    <= state_nxt;
         prev     <= prev_nxt;
         run      <= run_nxt;
         locked   <= (state_nxt == S_LOCKED);
         err      <= err_nxt;
         err_cnt  <= err_cnt_nxt;
         wrap_cnt <= wrap_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: two instances (default counter width
// and a 2-bit counter width) driven in parallel and compared against a model.
module tb_counter_checker;

   localparam int WIDTH    = 4;
   localparam int LOCK_LEN = 4;
   localparam int MOD      = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en  = 1'b0;
   logic [WIDTH-1:0] q   = '0;

   logic       b_locked, b_err, s_locked, s_err;
   logic [7:0] b_errc, b_wrap;
   logic [1:0] s_errc, s_wrap;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit m_active, m_lock, m_err;
   int m_prev, m_run;
   int m_errc_b, m_wrap_b, m_errc_s, m_wrap_s;

   counter_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .q_in(q),
      .locked(b_locked), .err(b_err), .err_cnt(b_errc), .wrap_cnt(b_wrap)
   );

   counter_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .en(en), .q_in(q),
      .locked(s_locked), .err(s_err), .err_cnt(s_errc), .wrap_cnt(s_wrap)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   function automatic logic [23:0] observed();
      return {b_locked, b_err, b_errc, b_wrap, s_locked, s_err, s_errc, s_wrap};
   endfunction

   function automatic logic [23:0] expected();
      return {m_lock, m_err, 8'(m_errc_b), 8'(m_wrap_b),
              m_lock, m_err, 2'(m_errc_s), 2'(m_wrap_s)};
   endfunction

   task automatic model_reset();
      m_active = 0; m_lock = 0; m_err = 0; m_prev = 0; m_run = 0;
      m_errc_b = 0; m_wrap_b = 0; m_errc_s = 0; m_wrap_s = 0;
   endtask

   // Model one rising edge from the rules: lock after LOCK_LEN good steps,
   // report and count misses once locked, count wraps made while locked.
   task automatic model_edge(input bit e, input int v);
      bit good;
      m_err = 0;
      if (!e) begin
         m_active = 0; m_lock = 0; m_run = 0;
      end else if (!m_active) begin
         m_active = 1; m_prev = v; m_run = 0;
      end else begin
         good = (v == (m_prev + 1) % MOD);
         if (m_lock) begin
            if (good) begin
               if (m_prev == MOD - 1) begin
                  m_wrap_b = sat(m_wrap_b + 1, 255);
                  m_wrap_s = sat(m_wrap_s + 1, 3);
               end
            end else begin
               m_err = 1; m_lock = 0; m_run = 0;
               m_errc_b = sat(m_errc_b + 1, 255);
               m_errc_s = sat(m_errc_s + 1, 3);
            end
         end else if (good) begin
            m_run++;
            if (m_run >= LOCK_LEN) m_lock = 1;
         end else begin
            m_run = 0;
         end
         m_prev = v;
      end
   endtask

   // Drive inputs, clock one edge, update model, settle just after the edge.
   task automatic applyStimulus(input bit e, input int v);
      en = e;
      q  = WIDTH'(v);
      @(posedge clk);
      model_edge(e, v);
      #1;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (observed() !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_async: observed %h required %h", observed(), 24'h0);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      applyReset();
      checks++;
      if (observed() !== expected()) begin
         errors++;
         $display("[TB] FAIL reset_hold: observed %h required %h", observed(), expected());
      end
   endtask

   task automatic test_lock();
      for (int i = 0; i <= 4; i++) begin
         applyStimulus(1, i);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL lock step %0d: observed %h required %h", i, observed(), expected());
         end
      end
      checks++;
      if (b_locked !== 1'b1 || b_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lock_after_4: observed locked=%b err=%b required locked=1 err=0", b_locked, b_err);
      end
   endtask

   task automatic test_wrap();
      for (int i = 5; i <= 16; i++) begin
         applyStimulus(1, i % MOD);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL wrap step %0d: observed %h required %h", i, observed(), expected());
         end
      end
      checks++;
      if (b_wrap !== 8'd1 || b_locked !== 1'b1 || b_errc !== 8'd0) begin
         errors++;
         $display("[TB] FAIL wrap_count: observed wrap=%0d locked=%b errc=%0d required 1 1 0", b_wrap, b_locked, b_errc);
      end
   endtask

   task automatic test_error();
      for (int i = 1; i <= 7; i++) applyStimulus(1, i);
      applyStimulus(1, 9);
      checks++;
      if (b_err !== 1'b1 || b_locked !== 1'b0 || b_errc !== 8'd1) begin
         errors++;
         $display("[TB] FAIL err_pulse: observed err=%b locked=%b errc=%0d required 1 0 1", b_err, b_locked, b_errc);
      end
      for (int i = 10; i <= 13; i++) begin
         applyStimulus(1, i);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL relock step %0d: observed %h required %h", i, observed(), expected());
         end
      end
      checks++;
      if (b_locked !== 1'b1 || b_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL relock_13: observed locked=%b err=%b required 1 0", b_locked, b_err);
      end
   endtask

   task automatic test_hold();
      applyReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 0);
         checks++;
         if (observed() !== expected() || b_locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold cycle %0d: observed %h required %h", i, observed(), expected());
         end
      end
      for (int i = 1; i <= 4; i++) applyStimulus(1, i);
      checks++;
      if (b_locked !== 1'b1 || b_errc !== 8'd0 || observed() !== expected()) begin
         errors++;
         $display("[TB] FAIL hold_relock: observed %h required locked=1 errc=0 (%h)", observed(), expected());
      end
   endtask

   task automatic test_en_drop();
      applyStimulus(0, 9);
      checks++;
      if (b_err !== 1'b0 || b_locked !== 1'b0 || b_errc !== 8'd0 || b_wrap !== 8'd0) begin
         errors++;
         $display("[TB] FAIL en_drop: observed %h required locked=0 err=0 counters 0", observed());
      end
      for (int i = 3; i <= 7; i++) begin
         applyStimulus(1, i);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL en_relock value %0d: observed %h required %h", i, observed(), expected());
         end
      end
      checks++;
      if (b_locked !== 1'b1) begin
         errors++;
         $display("[TB] FAIL en_relock_final: observed locked=%b required 1", b_locked);
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < LOCK_LEN; i++) applyStimulus(1, (m_prev + 1) % MOD);
         applyStimulus(1, (m_prev + 2) % MOD);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL saturate round %0d: observed %h required %h", k, observed(), expected());
         end
      end
      checks++;
      if (s_errc !== 2'd3 || b_errc !== 8'd5) begin
         errors++;
         $display("[TB] FAIL saturate_final: observed small=%0d big=%0d required 3 5", s_errc, b_errc);
      end
   endtask

   task automatic test_random();
      int r, v;
      bit e;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         e = (r >= 4);
         if (r < 85)      v = (m_prev + 1) % MOD;
         else if (r < 92) v = m_prev;
         else             v = $urandom_range(0, MOD - 1);
         applyStimulus(e, v);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL random cycle %0d: observed %h required %h", n, observed(), expected());
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) applyStimulus(1, (m_prev + 1) % MOD);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (observed() !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid: observed %h required %h", observed(), 24'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_lock();
      test_wrap();
      test_error();
      test_hold();
      test_en_drop();
      test_saturate();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side monitor for the free-running up-counter output bus (Q). Samples the bus every clock, predicts the next value (previous + 1, modulo 2^WIDTH), and declares lock after a run of correct increments.
- Flags and counts mismatches, counts wrap-arounds, and resynchronises automatically.
- Sits beside the counter in benches and on silicon as a self-check block.

Parameters:
WIDTH, 4, width of the observed counter bus
LOCK_LEN, 4, consecutive correct increments required to enter LOCKED (>=1)
CNT_W, 8, width of the error and wrap counters (saturating)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
EN  input  1  checking enable; 0 forces IDLE
Q_IN  input  WIDTH  observed counter value, sampled every rising CLK edge
LOCKED  output  1  1 while in LOCKED state
ERR  output  1  one-cycle pulse on a mismatch detected in LOCKED
ERR_CNT  output  CNT_W  number of mismatches since reset, saturates at all-ones
WRAP_CNT  output  CNT_W  number of correct all-ones->0 transitions seen in LOCKED, saturates

Behaviour:
- One clock domain. RST is asynchronous and active-high; it is applied immediately and released synchronously by the user.
- Reset values:
  - state = IDLE
  - LOCKED = 0, ERR = 0, ERR_CNT = 0, WRAP_CNT = 0
  - internal prev register = 0, run counter = 0
- All outputs are registered. Mismatch-to-ERR latency is 1 cycle: Q_IN is sampled at edge N and ERR is high after edge N for exactly one cycle.
- State machine (IDLE, SYNC, TRACK, LOCKED):
  - IDLE: if EN=1, capture Q_IN into prev and go to SYNC; otherwise stay.
  - SYNC / TRACK: each edge compare Q_IN with prev+1 (mod 2^WIDTH).
    - Match: increment run and store prev=Q_IN. When run reaches LOCK_LEN, go to LOCKED; otherwise go or stay in TRACK.
    - Mismatch: set run=0, prev=Q_IN, stay in SYNC. No ERR pulse and no ERR_CNT increment (not yet locked).
  - LOCKED: each edge compare Q_IN with prev+1.
    - Match: prev=Q_IN. If prev was all-ones and Q_IN=0, increment WRAP_CNT (saturating).
    - Mismatch: ERR pulse, ERR_CNT+1 (saturating), prev=Q_IN, run=0, go to SYNC.
  - Any state, EN=0 at an edge: go to IDLE and set run=0. ERR_CNT and WRAP_CNT hold their values.
- LOCKED output is high exactly when state=LOCKED.
- Arithmetic rules:
  - prev+1 is computed in WIDTH bits, so all-ones+1 = 0 is a valid increment.
  - A held value (Q_IN = prev, as while the counter sits in its own reset) is a mismatch.
  - The counters saturate at 2^CNT_W-1 and never roll over.
- Simultaneous events:
  - A mismatch on the same edge that EN falls: EN=0 has priority. Go to IDLE with no ERR pulse.
  - The final correct increment that reaches LOCK_LEN on a wrap transition is not counted in WRAP_CNT; only transitions made while already in LOCKED count.
- RST mid-operation clears everything asynchronously, including the counters.

Test Plan:
- RST=1, then RST=0 with EN=1 and Q_IN stepping 0,1,2,3,4 on successive edges -> LOCKED rises after the edge sampling 4 (LOCK_LEN=4); ERR stays 0 throughout.
- Locked, Q_IN continues 5..15 then 0 -> WRAP_CNT=1, LOCKED stays 1, ERR_CNT=0.
- Locked at Q_IN=7, next sample 9 -> ERR high for exactly one cycle, ERR_CNT=1, LOCKED=0. Then 10,11,12,13 -> relock after the edge sampling 13.
- Q_IN held at 0 for 20 cycles with EN=1 (counter held in reset) -> state stays SYNC, LOCKED=0, ERR_CNT=0. Counting then resumes 1,2,3,4 -> lock.
- Locked, then EN=0 on the same edge as a bad sample -> IDLE, no ERR pulse, counters unchanged. EN=1 again -> relock after 4 correct increments.
- CNT_W=2, force 5 lock/mismatch cycles -> ERR_CNT reaches 3 and stays 3. Assert RST mid-stream -> all outputs 0 before the next CLK edge.
